// File: rtl/sdram_init.sv
// rtl/sdram_init.sv - SDR SDRAM power-up initialisation sequencer
// Waits out power-up, then issues precharge-all, AREF_NUM auto-refreshes and load-mode.
module sdram_init #(
    parameter int              T_POWER    = 20000,
    parameter int              TRP_CLK    = 2,
    parameter int              TRFC_CLK   = 7,
    parameter int              TMRD_CLK   = 3,
    parameter int              AREF_NUM   = 8,
    parameter logic [12:0]     MODE_VALUE = 13'h037
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic [3:0]  init_cmd,
    output logic [1:0]  init_ba,
    output logic [12:0] init_addr,
    output logic        init_end
);

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    typedef enum logic [2:0] {
        INIT_IDLE,
        INIT_PRE,
        INIT_TRP,
        INIT_AR,
        INIT_TRFC,
        INIT_MRS,
        INIT_TMRD,
        INIT_END
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt_power;
    logic [9:0]  cnt_clk;
    logic [3:0]  cnt_aref;

    logic [3:0]  cmd_d;
    logic [1:0]  ba_d;
    logic [12:0] addr_d;
    logic        end_d;

    always_comb begin
        state_next = state;
        case (state)
            INIT_IDLE: if (cnt_power == 16'(T_POWER - 1)) state_next = INIT_PRE;
            INIT_PRE:  state_next = INIT_TRP;
            INIT_TRP:  if (cnt_clk == 10'(TRP_CLK - 1)) state_next = INIT_AR;
            INIT_AR:   state_next = INIT_TRFC;
            INIT_TRFC: begin
                if (cnt_clk == 10'(TRFC_CLK - 1)) begin
                    if (cnt_aref < 4'(AREF_NUM)) state_next = INIT_AR;
                    else                         state_next = INIT_MRS;
                end
            end
            INIT_MRS:  state_next = INIT_TMRD;
            INIT_TMRD: if (cnt_clk == 10'(TMRD_CLK - 1)) state_next = INIT_END;
            INIT_END:  state_next = INIT_END;
            default:   state_next = INIT_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as it.
    always_comb begin
        cmd_d  = CMD_NOP;
        ba_d   = 2'b11;
        addr_d = 13'h1fff;
        end_d  = 1'b0;
        case (state_next)
            INIT_PRE: begin
                cmd_d  = CMD_PRE;
                ba_d   = 2'b00;
                addr_d = 13'h0400;
            end
            INIT_AR:  cmd_d = CMD_AREF;
            INIT_MRS: begin
                cmd_d  = CMD_MRS;
                ba_d   = 2'b00;
                addr_d = MODE_VALUE;
            end
            INIT_END: end_d = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= INIT_IDLE;
            cnt_power <= '0;
            cnt_clk   <= '0;
            cnt_aref  <= '0;
            init_cmd  <= CMD_NOP;
            init_ba   <= 2'b11;
            init_addr <= 13'h1fff;
            init_end  <= 1'b0;
        end else begin
            state     <= state_next;
            init_cmd  <= cmd_d;
            init_ba   <= ba_d;
            init_addr <= addr_d;
            init_end  <= end_d;
            if (state == INIT_IDLE)
                cnt_power <= cnt_power + 16'd1;
            // Only the wait states count, so nothing wraps while parked in INIT_END.
            if (state_next != state)
                cnt_clk <= '0;
            else if (state == INIT_TRP || state == INIT_TRFC || state == INIT_TMRD)
                cnt_clk <= cnt_clk + 10'd1;
            if (state == INIT_AR)
                cnt_aref <= cnt_aref + 4'd1;
        end
    end

endmodule
